// File: rtl/mlp_sample_sequencer.sv
// mlp_sample_sequencer: serial feature loader, settle timer and result register
// for the printed-MLP classifier. Define GOLDEN_CMP_EN for golden-class compare.
module mlp_sample_sequencer #(
    parameter int NUM_A         = 21,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int IDX_W         = 16,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH_A-1:0]         feat_in,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic [OUTWIDTH-1:0]        res_class,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [IDX_W-1:0]           res_index,
    output logic                       busy
`ifdef GOLDEN_CMP_EN
    ,
    input  logic [OUTWIDTH-1:0]        exp_class,
    output logic                       res_mismatch,
    output logic [CNT_W-1:0]           mismatch_cnt
`endif
);

    localparam int CW  = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST   = CW'(NUM_A - 1);
    localparam logic [SCW-1:0] SETTLE = SCW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        LOAD,
        SETTLING,
        HOLD
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  count;
    logic [SCW-1:0] scnt;
    logic           accept;
    logic           last;
    logic           capture;
    logic           release_res;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        feat_ready  = 1'b0;
        accept      = 1'b0;
        last        = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        unique case (state)
            LOAD: begin
                feat_ready = 1'b1;
                accept     = feat_valid;
                last       = feat_valid && (count == LAST);
                if (last) state_n = SETTLING;
            end
            SETTLING: begin
                capture = (scnt == SCW'(1));
                if (capture) state_n = HOLD;
            end
            HOLD: begin
                release_res = res_ready;
                if (res_ready) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    assign busy = (state != LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            scnt      <= '0;
            mlp_inp   <= '0;
            res_class <= '0;
            res_valid <= 1'b0;
            res_index <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < NUM_A; k++)
                    if (count == CW'(k))
                        mlp_inp[k*WIDTH_A +: WIDTH_A] <= feat_in;
                count <= last ? '0 : count + CW'(1);
            end
            if (last) scnt <= SETTLE;
            else if (state == SETTLING) scnt <= scnt - SCW'(1);
            if (capture) begin
                res_class <= mlp_out;
                res_valid <= 1'b1;
            end
            if (release_res) begin
                res_valid <= 1'b0;
                res_index <= res_index + IDX_W'(1);
            end
        end
    end

`ifdef GOLDEN_CMP_EN
    logic [OUTWIDTH-1:0] exp_q;
    logic                miss;

    assign miss = (mlp_out != exp_q);

    // counter sticks at all-ones once saturated
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q        <= '0;
            res_mismatch <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            if (last) exp_q <= exp_class;
            if (capture) begin
                res_mismatch <= miss;
                if (miss && (mismatch_cnt != '1))
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// tb_mlp_sample_sequencer: randomized scoreboard bench for mlp_sample_sequencer.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_mlp_sample_sequencer;

    localparam int NA = 21;
    localparam int WA = 4;
    localparam int OW = 2;
    localparam int SC = 4;
    localparam int IW = 16;
    localparam int CW = 2;
    localparam int VW = NA * WA;

    logic          clk = 1'b0;
    logic          rst;
    logic [WA-1:0] feat_in;
    logic          feat_valid;
    logic          feat_ready;
    logic [VW-1:0] mlp_inp;
    logic [OW-1:0] mlp_out;
    logic [OW-1:0] res_class;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_index;
    logic          busy;
`ifdef GOLDEN_CMP_EN
    logic [OW-1:0] exp_class;
    logic          res_mismatch;
    logic [CW-1:0] mismatch_cnt;
`endif

    always #5 clk = ~clk;

    mlp_sample_sequencer #(
        .NUM_A(NA), .WIDTH_A(WA), .OUTWIDTH(OW),
        .SETTLE_CYCLES(SC), .IDX_W(IW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .feat_in(feat_in), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .mlp_inp(mlp_inp), .mlp_out(mlp_out),
        .res_class(res_class), .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .busy(busy)
`ifdef GOLDEN_CMP_EN
        , .exp_class(exp_class), .res_mismatch(res_mismatch),
        .mismatch_cnt(mismatch_cnt)
`endif
    );

    typedef struct {
        logic [VW-1:0] inp;
        logic [OW-1:0] cls;
        logic [IW-1:0] idx;
        logic [OW-1:0] ecls;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    logic [OW-1:0] ecls_v;
    logic [IW-1:0] idx;
    bit            rr_all = 1'b1;
    bit            bp_done = 1'b0;

`ifdef GOLDEN_CMP_EN
    assign exp_class = ecls_v;
`endif

    // result consumer: always ready for sample 0, a 10-cycle stall on
    // result 1, random backpressure otherwise
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid && res_index == IW'(1) && !bp_done) begin
                res_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                bp_done   = 1'b1;
                res_ready = 1'b1;
            end else if (rr_all) begin
                res_ready = 1'b1;
            end else begin
                res_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // monitor / scoreboard
    bit            holding = 1'b0;
    bit            released = 1'b0;
    logic [IW-1:0] rel_idx;
    logic [VW-1:0] snap_inp;
    logic [OW-1:0] snap_cls;
    exp_t          e;
    int            model_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            holding   = 1'b0;
            released  = 1'b0;
            model_cnt = 0;
        end else begin
            if (released) begin
                chk("ready_after_release", feat_ready, 1'b1);
                chk("valid_after_release", res_valid, 1'b0);
                chk("index_increment", res_index, rel_idx + IW'(1));
                released = 1'b0;
            end
            if (res_valid) begin
                if (!holding) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", res_valid, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk("res_inp", mlp_inp, e.inp);
                        chk("res_class", res_class, e.cls);
                        chk("res_index", res_index, e.idx);
`ifdef GOLDEN_CMP_EN
                        if (e.cls != e.ecls && model_cnt < (1 << CW) - 1)
                            model_cnt++;
                        chk("res_mismatch", res_mismatch, e.cls != e.ecls);
                        chk("mismatch_cnt", mismatch_cnt, model_cnt);
`endif
                    end
                    snap_inp = mlp_inp;
                    snap_cls = res_class;
                    holding  = 1'b1;
                end else begin
                    chk("hold_inp", mlp_inp, snap_inp);
                    chk("hold_class", res_class, snap_cls);
                end
                chk("hold_feat_ready", feat_ready, 1'b0);
                chk("hold_busy", busy, 1'b1);
                if (res_ready) begin
                    holding  = 1'b0;
                    released = 1'b1;
                    rel_idx  = res_index;
                end
            end
        end
    end

    // mode 0: k+1 pattern, mlp_out 2; 1: gapped; 2: random; 3: settle glitch
    task automatic send_sample(input int mode, input bit do_rst);
        logic [WA-1:0] d[NA];
        logic [OW-1:0] r[SC+1];
        logic [VW-1:0] inp;
        exp_t          x;
        int            k;
        bit            tog, hs;
        for (int i = 0; i < NA; i++)
            d[i] = (mode == 0) ? WA'((i + 1) % (1 << WA)) : WA'($urandom);
        for (int j = 0; j <= SC; j++)
            if (mode == 0)      r[j] = OW'(2);
            else if (mode == 3) r[j] = (j == SC) ? OW'(3) : OW'(1);
            else                r[j] = OW'($urandom);
        ecls_v = (mode == 0) ? OW'(1) : OW'($urandom);
        inp = '0;
        for (int i = 0; i < NA; i++)
            inp[i*WA +: WA] = d[i];
        k   = 0;
        tog = 1'b1;
        while (k < NA) begin
            if (mode == 0)      feat_valid = 1'b1;
            else if (mode == 1) feat_valid = tog;
            else                feat_valid = ($urandom_range(0, 2) != 0);
            tog     = ~tog;
            feat_in = feat_valid ? d[k] : WA'($urandom);
            @(negedge clk);
            hs = feat_valid && feat_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
        end
        feat_valid = 1'b0;
        if (do_rst) begin
            @(negedge clk);
            chk("settle_busy", busy, 1'b1);
            chk("loading_index", res_index, idx);
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("midrst_inp", mlp_inp, '0);
            chk("midrst_class", res_class, '0);
            chk("midrst_valid", res_valid, 1'b0);
            chk("midrst_index", res_index, '0);
            chk("midrst_ready", feat_ready, 1'b1);
            chk("midrst_busy", busy, 1'b0);
            idx = '0;
            @(posedge clk);
            #1;
            return;
        end
        x.inp  = inp;
        x.cls  = r[SC];
        x.idx  = idx;
        x.ecls = ecls_v;
        q.push_back(x);
        for (int j = 1; j <= SC; j++) begin
            mlp_out = r[j];
            if (j == SC) begin
                @(negedge clk);
                chk("pre_capture_valid", res_valid, 1'b0);
                chk("pre_capture_busy", busy, 1'b1);
            end
            @(posedge clk);
            #1;
        end
        mlp_out = OW'($urandom);
        @(negedge clk);
        chk("capture_edge_valid", res_valid, 1'b1);
        idx = idx + IW'(1);
    endtask

    initial begin
        rst        = 1'b1;
        feat_valid = 1'b0;
        feat_in    = '0;
        mlp_out    = '0;
        ecls_v     = '0;
        idx        = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_inp", mlp_inp, '0);
        chk("reset_class", res_class, '0);
        chk("reset_valid", res_valid, 1'b0);
        chk("reset_index", res_index, '0);
        chk("reset_ready", feat_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        send_sample(0, 1'b0);
        rr_all = 1'b0;
        send_sample(1, 1'b0);
        send_sample(2, 1'b0);
        send_sample(2, 1'b1);
        send_sample(3, 1'b0);
        repeat (8) send_sample(2, 1'b0);
        for (int i = 0; i < 500 && (q.size() != 0 || res_valid); i++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain_queue", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
